switch_status_tx: RTL and testbench

Transmit side of the switch-reader link. Synchronises and debounces the 20 limit-switch inputs, then sends their state to the control host as a 3-byte UART frame. A frame goes out whenever the debounced state changes or the host pulses a request. The block also drives the aggregate all-closed line on OUT and LED, for boards that need both the summary and per-switch status.

---
 rtl/switch_status_tx_if.sv | 13 +
 rtl/switch_status_tx.sv | 176 +++++++++++++++++
 tb/tb_switch_status_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_status_tx_if.sv
// Signal bundle between the switch-status transmitter and its board/host side:
// raw switch inputs and host request in, UART line and status lines out.
interface switch_status_tx_if;
    logic [19:0] IN;
    logic        req;
    logic        TX;
    logic        busy;
    logic        OUT;
    logic        LED;

    modport master (output IN, output req, input TX, input busy, input OUT, input LED);
    modport slave  (input IN, input req, output TX, output busy, output OUT, output LED);
endinterface

// File: rtl/switch_status_tx.sv
// Synchronises and debounces 20 limit switches and sends them to the host as a UART frame.
// Define SWITCH_TX_HEADER_EN to prefix every frame with a 0xA5 sync byte.
module switch_status_tx #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    switch_status_tx_if.slave bus
);
`ifdef SWITCH_TX_HEADER_EN
    localparam int NUM_BYTES = 4;
`else
    localparam int NUM_BYTES = 3;
`endif
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [19:0]   meta_q, sync_q, sync_dly_q, deb_q, deb_d;
    logic [DW-1:0] cnt_q;
    logic          chg_q, out_q, stable;

    // Accept only when the synchronised vector is still unchanged on the accepting cycle,
    // so a saturated counter cannot let a fresh edge straight through.
    assign stable = (sync_q == sync_dly_q);

    always_comb begin
        deb_d = deb_q;
        if (stable && cnt_q == DEB_LAST) deb_d = sync_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            sync_dly_q <= '0;
            cnt_q      <= '0;
            deb_q      <= '0;
            chg_q      <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            meta_q     <= bus.IN;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            if (!stable)               cnt_q <= '0;
            else if (cnt_q != DEB_LAST) cnt_q <= cnt_q + DW'(1);
            deb_q      <= deb_d;
            chg_q      <= (deb_d != deb_q);
            out_q      <= &deb_d;
        end
    end

    state_e        state_q, state_d;
    logic [BW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    sh_q, sh_d, frame_byte;
    logic [19:0]   shadow_q, shadow_d;
    logic          tx_q, tx_d, busy_q, busy_d, pend_q, pend_d, launch, bit_end;

    assign bit_end = (clk_cnt_q == BIT_LAST);

    always_comb begin
        frame_byte = 8'h00;
        case (byte_q)
`ifdef SWITCH_TX_HEADER_EN
            2'd0: frame_byte = 8'hA5;
            2'd1: frame_byte = shadow_q[7:0];
            2'd2: frame_byte = shadow_q[15:8];
            2'd3: frame_byte = {&shadow_q, 3'b000, shadow_q[19:16]};
`else
            2'd0:    frame_byte = shadow_q[7:0];
            2'd1:    frame_byte = shadow_q[15:8];
            2'd2:    frame_byte = {&shadow_q, 3'b000, shadow_q[19:16]};
            default: frame_byte = 8'h00;
`endif
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + BW'(1);
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        shadow_d  = shadow_q;
        launch    = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (pend_q) begin
                    state_d  = START;
                    byte_d   = '0;
                    shadow_d = deb_q;
                    launch   = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    sh_d    = frame_byte;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == BYTE_LAST) begin
                        byte_d = '0;
                        if (pend_q) begin
                            state_d  = START;
                            shadow_d = deb_q;
                            launch   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A trigger landing on the launch cycle survives and yields one follow-up frame.
        pend_d = (pend_q & ~launch) | bus.req | chg_q;

        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = sh_d[0];
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sh_q      <= '0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sh_q      <= sh_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.TX   = tx_q;
    assign bus.busy = busy_q;
    assign bus.OUT  = out_q;
    assign bus.LED  = out_q;
endmodule

// File: tb/tb_switch_status_tx.sv
// Directed bench for switch_status_tx: a frame-position model checked every cycle,
// a UART receiver for byte contents, and literal latency/length expectations.
module tb_switch_status_tx;
    localparam int CLKS = 4;
    localparam int DEB  = 8;
`ifdef SWITCH_TX_HEADER_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int FRAME_LEN = NB * 10 * CLKS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_status_tx_if bus();

    switch_status_tx #(.CLKS_PER_BIT(CLKS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: deb accepts a value once IN was sampled identical on DEB+1 consecutive
    // edges ending two edges ago; a frame is a position counter 0..FRAME_LEN-1.
    logic        m_busy, m_pend, m_chg, m_out;
    int          m_pos;
    logic [19:0] m_deb, m_shadow;
    logic [19:0] hist [DEB+3];

    function automatic logic [7:0] frame_byte(input logic [19:0] s, input int idx);
        logic [7:0] b [NB];
        int k = 0;
`ifdef SWITCH_TX_HEADER_EN
        b[0] = 8'hA5;
        k = 1;
`endif
        b[k]   = s[7:0];
        b[k+1] = s[15:8];
        b[k+2] = {&s, 3'b000, s[19:16]};
        return b[idx];
    endfunction

    function automatic logic exp_tx();
        int slot;
        logic [7:0] b;
        if (!m_busy) return 1'b1;
        slot = (m_pos % (10 * CLKS)) / CLKS;
        b = frame_byte(m_shadow, m_pos / (10 * CLKS));
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    initial begin : model
        bit started, stable;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0; m_pos = 0; m_pend = 0; m_chg = 0; m_out = 0;
                m_deb = '0; m_shadow = '0;
                for (int k = 0; k < DEB + 3; k++) hist[k] = '0;
            end else begin
                started = 0;
                if (m_busy) begin
                    m_pos++;
                    if (m_pos == FRAME_LEN) begin
                        m_pos = 0;
                        if (m_pend) begin m_shadow = m_deb; started = 1; end
                        else m_busy = 0;
                    end
                end else if (m_pend) begin
                    m_busy = 1; m_pos = 0; m_shadow = m_deb; started = 1;
                end
                m_pend = (m_pend && !started) || bus.req || m_chg;
                for (int k = DEB + 2; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = bus.IN;
                stable = 1;
                for (int k = 3; k <= DEB + 2; k++) if (hist[k] != hist[2]) stable = 0;
                m_chg = 0;
                if (stable && hist[2] != m_deb) begin m_deb = hist[2]; m_chg = 1; end
                m_out = &m_deb;
            end
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("tx", bus.TX, exp_tx());
            check("busy", bus.busy, m_busy);
            check("out", bus.OUT, m_out);
            check("led", bus.LED, m_out);
        end
    end

    logic [7:0] rx_q [$];

    initial begin : rx
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && bus.TX == 1'b0) begin
                repeat (CLKS / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    b[i] = bus.TX;
                end
                repeat (CLKS) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic measure_busy(output int len);
        int guard = 0;
        len = 0;
        while (!bus.busy && guard < 400) begin @(negedge clk); guard++; end
        while (bus.busy && len < 1000) begin len++; @(negedge clk); end
    endtask

    task automatic check_frame(input string name, input logic [7:0] e0, e1, e2);
        logic [7:0] exp [$];
        logic [7:0] got;
`ifdef SWITCH_TX_HEADER_EN
        exp.push_back(8'hA5);
`endif
        exp.push_back(e0);
        exp.push_back(e1);
        exp.push_back(e2);
        foreach (exp[i]) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check($sformatf("%s_b%0d", name, i), got, exp[i]);
        end
    endtask

    task automatic pulse_req();
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic watch_idle(input string name, input int cycles);
        logic saw = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.busy) saw = 1'b1;
        end
        check(name, saw, 1'b0);
    endtask

    initial begin : stim
        int len, n;
        rst = 1'b1;
        bus.IN = 20'hFFFFF;
        bus.req = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_tx", bus.TX, 1'b1);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_out", bus.OUT, 1'b0);
        end
        bus.IN = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        rx_q.delete();

        // Step to all-closed: OUT rises 10 edges after the first sampling edge.
        bus.IN = 20'hFFFFF;
        n = -1;
        do begin @(posedge clk); n++; #1; end while (!bus.OUT && n < 40);
        check("deb_latency", n, 10);
        @(negedge clk);
        measure_busy(len);
        check("deb_busy_len", len, FRAME_LEN);
        check("deb_nbytes", rx_q.size(), NB);
        check_frame("deb", 8'hFF, 8'hFF, 8'h8F);

        // Short glitch on one switch must be ignored.
        repeat (5) @(negedge clk);
        bus.IN[5] = 1'b0;
        repeat (5) @(negedge clk);
        bus.IN[5] = 1'b1;
        watch_idle("glitch_no_frame", 40);
        check("glitch_out", bus.OUT, 1'b1);
        check("glitch_nbytes", rx_q.size(), 0);

        // New switch pattern, then a host request.
        bus.IN = 20'h12345;
        measure_busy(len);
        check("chg_busy_len", len, FRAME_LEN);
        check("chg_nbytes", rx_q.size(), NB);
        check_frame("chg", 8'h45, 8'h23, 8'h01);
        repeat (10) @(negedge clk);
        pulse_req();
        check("req_tx_hold", bus.TX, 1'b1);
        check("req_busy_hold", bus.busy, 1'b0);
        @(negedge clk);
        check("req_tx_fall", bus.TX, 1'b0);
        check("req_busy_rise", bus.busy, 1'b1);
        measure_busy(len);
        check("req_busy_len", len, FRAME_LEN);
        check("req_nbytes", rx_q.size(), NB);
        check_frame("req", 8'h45, 8'h23, 8'h01);

        // Two requests and a debounced change mid-frame: one back-to-back follow-up.
        repeat (10) @(negedge clk);
        rx_q.delete();
        pulse_req();
        fork
            measure_busy(len);
            begin
                repeat (8) @(negedge clk);
                pulse_req();
                bus.IN = 20'hABCDE;
                repeat (50) @(negedge clk);
                pulse_req();
            end
        join
        check("mid_busy_len", len, 2 * FRAME_LEN);
        check("mid_nbytes", rx_q.size(), 2 * NB);
        check_frame("mid_first", 8'h45, 8'h23, 8'h01);
        check_frame("mid_follow", 8'hDE, 8'hBC, 8'h0A);
        watch_idle("mid_no_third", 60);

        // Reset during B1 data bits aborts the frame and drops any pending trigger.
        rx_q.delete();
        pulse_req();
        repeat (50) @(negedge clk);
        check("rstmid_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        bus.IN = '0;
        @(negedge clk);
        check("rstmid_tx", bus.TX, 1'b1);
        check("rstmid_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        watch_idle("rstmid_no_frame", 80);
        check("rstmid_out", bus.OUT, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
